// File: rtl/nanoice40_pkg.sv
// nanoice40_pkg: shared debounce state encodings and event field widths
package nanoice40_pkg;
  localparam logic [0:0] DB_STABLE   = 1'b0;
  localparam logic [0:0] DB_SETTLING = 1'b1;
  localparam int EVT_KIND_W = 1;
  function automatic int chan_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/btn_debounce_bank_if.sv
// btn_debounce_bank_if: valid/ready button event port
interface btn_debounce_bank_if #(parameter int N_BTN = 4);
  logic valid;
  logic ready;
  logic press;
  logic [nanoice40_pkg::chan_w(N_BTN)-1:0] chan;
  modport master(output valid, chan, press, input ready);
  modport slave(input valid, chan, press, output ready);
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one channel of synchronizer, debounce FSM and qualification counter
module btn_debounce_ch import nanoice40_pkg::*; #(
  parameter int DB_CYCLES = 120000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls,
  output logic commit,
  output logic s
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [1:0] sync_q;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, rls_q, rls_d;
  assign s = sync_q[1];
  assign level = level_q;
  assign press = press_q;
  assign rls = rls_q;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    commit = 1'b0;
    if (state_q == DB_STABLE)
      state_d = (s != level_q) ? DB_SETTLING : DB_STABLE;
    else if (s == level_q)
      state_d = DB_STABLE;
    else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      state_d = DB_STABLE;
      commit = 1'b1;
    end else
      cnt_d = cnt_q + CW'(1);
    level_d = commit ? s : level_q;
    press_d = commit & s;
    rls_d = commit & ~s;
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      state_q <= DB_STABLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rls_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rls_q <= rls_d;
    end
  end
endmodule

// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: debounced button bank with a single-entry press/release event register
module btn_debounce_bank import nanoice40_pkg::*; #(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = 120000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [N_BTN-1:0]    btn_raw,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  output logic [N_BTN-1:0]    btn_release,
  output logic                evt_ovf,
  input  logic                ovf_clr,
  btn_debounce_bank_if.master evt
);
  localparam int CW = chan_w(N_BTN);
  // Inverting ahead of the synchronizer lets channels reset to 0, i.e. the idle pin level
  logic [N_BTN-1:0] btn_in, commit, s, hot, load_mask;
  logic [N_BTN-1:0] pending_q, pending_d, kind_q, kind_d;
  logic [CW-1:0] sel, evt_chan_q, evt_chan_d;
  logic any, sel_kind, load;
  logic evt_valid_q, evt_valid_d, evt_press_q, evt_press_d, evt_ovf_q, evt_ovf_d;
  assign btn_in = btn_raw ^ {N_BTN{ACTIVE_LOW != 0}};
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk_in(clk_in), .rst_n(rst_n), .raw(btn_in[i]),
      .level(btn_level[i]), .press(btn_press[i]), .rls(btn_release[i]),
      .commit(commit[i]), .s(s[i])
    );
  end
  always_comb begin
    sel = '0;
    sel_kind = 1'b0;
    hot = '0;
    any = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (pending_q[i]) begin
        sel = CW'(i);
        sel_kind = kind_q[i];
        hot = '0;
        hot[i] = 1'b1;
        any = 1'b1;
      end
    load = !evt_valid_q || evt.ready;
    load_mask = (load && any) ? hot : '0;
    pending_d = (pending_q & ~load_mask) | commit;
    kind_d = (kind_q & ~commit) | (s & commit);
    evt_valid_d = load ? any : evt_valid_q;
    evt_chan_d = (load && any) ? sel : evt_chan_q;
    evt_press_d = (load && any) ? sel_kind : evt_press_q;
    evt_ovf_d = (|(commit & pending_q & ~load_mask)) | (evt_ovf_q & ~ovf_clr);
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      kind_q <= '0;
      evt_valid_q <= 1'b0;
      evt_chan_q <= '0;
      evt_press_q <= 1'b0;
      evt_ovf_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      kind_q <= kind_d;
      evt_valid_q <= evt_valid_d;
      evt_chan_q <= evt_chan_d;
      evt_press_q <= evt_press_d;
      evt_ovf_q <= evt_ovf_d;
    end
  end
  assign evt.valid = evt_valid_q;
  assign evt.chan = evt_chan_q;
  assign evt.press = evt_press_q;
  assign evt_ovf = evt_ovf_q;
endmodule

// File: tb/tb_btn_debounce_bank.sv
// tb_btn_debounce_bank: directed stimulus with an event scoreboard for btn_debounce_bank
module tb_btn_debounce_bank;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn_raw, btn_level, btn_press, btn_release, strobe_acc;
  logic evt_ovf, ovf_clr;
  int n_chk = 0;
  int n_bad = 0;
  int sb[$];
  btn_debounce_bank_if #(.N_BTN(4)) evt_if();
  btn_debounce_bank #(.N_BTN(4), .DB_CYCLES(8), .ACTIVE_LOW(1)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .evt_ovf(evt_ovf),
    .ovf_clr(ovf_clr), .evt(evt_if)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      strobe_acc |= btn_press | btn_release;
    end
  endtask
  task automatic accept();
    chk("accept_valid", int'(evt_if.valid), 1);
    evt_if.ready = 1'b1;
    run(1);
    evt_if.ready = 1'b0;
  endtask
  always @(negedge clk_in)
    if (rst_n && evt_if.valid && evt_if.ready) begin
      if (sb.size() == 0)
        chk("evt_unexpected", int'(evt_if.chan) * 2 + int'(evt_if.press), -1);
      else
        chk("evt_pop", int'(evt_if.chan) * 2 + int'(evt_if.press), sb.pop_front());
    end
  initial begin
    btn_raw = 4'hF;
    evt_if.ready = 1'b0;
    ovf_clr = 1'b0;
    strobe_acc = '0;
    run(3);
    rst_n = 1'b1;
    strobe_acc = '0;
    run(20);
    chk("idle_level", int'(btn_level), 0);
    chk("idle_strobes", int'(strobe_acc), 0);
    chk("idle_valid", int'(evt_if.valid), 0);
    chk("idle_ovf", int'(evt_ovf), 0);
    btn_raw[0] = 1'b0;
    sb.push_back(0 * 2 + 1);
    run(10);
    chk("press0_early", int'(btn_press[0]), 0);
    run(1);
    chk("press0_strobe", int'(btn_press[0]), 1);
    chk("press0_level", int'(btn_level[0]), 1);
    chk("press0_valid_early", int'(evt_if.valid), 0);
    run(1);
    chk("press0_strobe_end", int'(btn_press[0]), 0);
    chk("press0_valid", int'(evt_if.valid), 1);
    chk("press0_chan", int'(evt_if.chan), 0);
    chk("press0_kind", int'(evt_if.press), 1);
    accept();
    strobe_acc = '0;
    repeat (3) begin
      btn_raw[1] = 1'b0;
      run(5);
      btn_raw[1] = 1'b1;
      run(5);
    end
    run(12);
    chk("bounce_strobes", int'(strobe_acc), 0);
    chk("bounce_level1", int'(btn_level[1]), 0);
    chk("bounce_valid", int'(evt_if.valid), 0);
    btn_raw[3:2] = 2'b00;
    sb.push_back(2 * 2 + 1);
    sb.push_back(3 * 2 + 1);
    run(12);
    chk("dual_valid", int'(evt_if.valid), 1);
    chk("dual_first_chan", int'(evt_if.chan), 2);
    accept();
    chk("dual_second_chan", int'(evt_if.chan), 3);
    accept();
    chk("dual_drained", int'(evt_if.valid), 0);
    btn_raw[0] = 1'b1;
    sb.push_back(0 * 2 + 0);
    run(12);
    chk("ovf_reg_kind", int'(evt_if.press), 0);
    btn_raw[0] = 1'b0;
    run(14);
    chk("ovf_not_yet", int'(evt_ovf), 0);
    btn_raw[0] = 1'b1;
    sb.push_back(0 * 2 + 0);
    run(14);
    chk("ovf_set", int'(evt_ovf), 1);
    accept();
    chk("ovf_second_chan", int'(evt_if.chan), 0);
    chk("ovf_second_kind", int'(evt_if.press), 0);
    accept();
    chk("ovf_sticky", int'(evt_ovf), 1);
    ovf_clr = 1'b1;
    run(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(evt_ovf), 0);
    btn_raw[3:2] = 2'b11;
    sb.push_back(2 * 2 + 0);
    sb.push_back(3 * 2 + 0);
    run(12);
    chk("rst_pre_valid", int'(evt_if.valid), 1);
    btn_raw[1] = 1'b0;
    run(5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level", int'(btn_level), 0);
    chk("rst_valid", int'(evt_if.valid), 0);
    chk("rst_chan", int'(evt_if.chan), 0);
    chk("rst_strobes", int'(btn_press | btn_release), 0);
    btn_raw[1] = 1'b1;
    sb.delete();
    run(3);
    rst_n = 1'b1;
    strobe_acc = '0;
    run(20);
    chk("post_rst_strobes", int'(strobe_acc), 0);
    chk("post_rst_valid", int'(evt_if.valid), 0);
    chk("post_rst_level", int'(btn_level), 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
